// File: rtl/fpdiv_ctrl.sv
// Sequencer for the Goldschmidt divider datapath: steps the register enables and
// operand selects through approximation, refinement and remainder, then holds the result.
module fpdiv_ctrl #(
    parameter int unsigned ITERS = 3
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [31:0] i_final_ans,
    input  logic [1:0]  i_op_type,
    output logic        o_en_a,
    output logic        o_en_b,
    output logic        o_en_rem,
    output logic [1:0]  o_sel_mux3,
    output logic [1:0]  o_sel_mux4,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_result,
    output logic [1:0]  o_result_op_type,
    output logic        o_result_valid
);

    localparam int unsigned CntW = $clog2(ITERS) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(ITERS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInitN,
        StInitD,
        StIterN,
        StIterD,
        StRem,
        StDone
    } state_e;

    state_e          r_state;
    state_e          w_state_d;
    logic [CntW-1:0] r_iter_cnt;
    logic [CntW-1:0] w_iter_cnt_d;
    logic [31:0]     r_result;
    logic [1:0]      r_result_op_type;
    logic            r_result_valid;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state          <= StIdle;
            r_iter_cnt       <= '0;
            r_result         <= '0;
            r_result_op_type <= '0;
            r_result_valid   <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_iter_cnt <= w_iter_cnt_d;
            if (r_state == StDone) begin
                r_result         <= i_final_ans;
                r_result_op_type <= i_op_type;
                r_result_valid   <= 1'b1;
            end else if (r_state == StIdle && i_start) begin
                r_result_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_iter_cnt_d = r_iter_cnt;
        o_en_a       = 1'b0;
        o_en_b       = 1'b0;
        o_en_rem     = 1'b0;
        o_sel_mux3   = 2'd0;
        o_sel_mux4   = 2'd0;
        o_busy       = 1'b1;
        o_done       = 1'b0;
        unique case (r_state)
            StIdle: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_state_d = StInitN;
                end
            end
            StInitN: begin
                o_en_a    = 1'b1;
                w_state_d = StInitD;
            end
            StInitD: begin
                o_en_b       = 1'b1;
                o_sel_mux4   = 2'd1;
                w_iter_cnt_d = '0;
                w_state_d    = StIterN;
            end
            StIterN: begin
                o_en_a     = 1'b1;
                o_sel_mux3 = 2'd1;
                o_sel_mux4 = 2'd2;
                w_state_d  = StIterD;
            end
            StIterD: begin
                o_en_b     = 1'b1;
                o_sel_mux3 = 2'd1;
                o_sel_mux4 = 2'd3;
                // Counter stops at the last pair so it never wraps.
                if (r_iter_cnt == LastCnt) begin
                    w_state_d = StRem;
                end else begin
                    w_iter_cnt_d = r_iter_cnt + CntW'(1);
                    w_state_d    = StIterN;
                end
            end
            StRem: begin
                o_en_rem   = 1'b1;
                o_sel_mux3 = 2'd2;
                o_sel_mux4 = 2'd2;
                w_state_d  = StDone;
            end
            StDone: begin
                o_done    = 1'b1;
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign o_result         = r_result;
    assign o_result_op_type = r_result_op_type;
    assign o_result_valid   = r_result_valid;

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Random-stimulus bench for fpdiv_ctrl with ITERS = 3 and ITERS = 1 instances, checked
// against a model that tracks only the cycle index since the accepting edge.
module tb_fpdiv_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] final_ans;
    logic [1:0]  op_type;

    logic        en_a [2];
    logic        en_b [2];
    logic        en_rem [2];
    logic [1:0]  sel3 [2];
    logic [1:0]  sel4 [2];
    logic        busy [2];
    logic        done [2];
    logic [31:0] result [2];
    logic [1:0]  result_op [2];
    logic        result_valid [2];

    int unsigned n_vec;
    int unsigned n_err;

    // Model state per instance: k = cycle number since accept (0 = idle).
    int unsigned m_iters [2];
    int unsigned m_k [2];
    logic [31:0] m_result [2];
    logic [1:0]  m_op [2];
    logic        m_valid [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fpdiv_ctrl #(.ITERS(3)) u_dut3 (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_start         (start),
        .i_final_ans     (final_ans),
        .i_op_type       (op_type),
        .o_en_a          (en_a[0]),
        .o_en_b          (en_b[0]),
        .o_en_rem        (en_rem[0]),
        .o_sel_mux3      (sel3[0]),
        .o_sel_mux4      (sel4[0]),
        .o_busy          (busy[0]),
        .o_done          (done[0]),
        .o_result        (result[0]),
        .o_result_op_type(result_op[0]),
        .o_result_valid  (result_valid[0])
    );

    fpdiv_ctrl #(.ITERS(1)) u_dut1 (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_start         (start),
        .i_final_ans     (final_ans),
        .i_op_type       (op_type),
        .o_en_a          (en_a[1]),
        .o_en_b          (en_b[1]),
        .o_en_rem        (en_rem[1]),
        .o_sel_mux3      (sel3[1]),
        .o_sel_mux4      (sel4[1]),
        .o_busy          (busy[1]),
        .o_done          (done[1]),
        .o_result        (result[1]),
        .o_result_op_type(result_op[1]),
        .o_result_valid  (result_valid[1])
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected {en_a, en_b, en_rem, sel3, sel4, busy, done} for cycle k of an operation.
    function automatic logic [8:0] exp_ctl(input int unsigned k, input int unsigned iters);
        if (k == 0)                      return 9'b0_0_0_00_00_0_0;
        else if (k == 1)                 return 9'b1_0_0_00_00_1_0;
        else if (k == 2)                 return 9'b0_1_0_00_01_1_0;
        else if (k <= 2 + 2 * iters)     return (k % 2 == 1) ? 9'b1_0_0_01_10_1_0
                                                             : 9'b0_1_0_01_11_1_0;
        else if (k == 2 * iters + 3)     return 9'b0_0_1_10_10_1_0;
        else                             return 9'b0_0_0_00_00_1_1;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_k[i]      = 0;
                m_result[i] = '0;
                m_op[i]     = '0;
                m_valid[i]  = 1'b0;
            end else if (m_k[i] == 0) begin
                if (start) begin
                    m_k[i]     = 1;
                    m_valid[i] = 1'b0;
                end
            end else if (m_k[i] == 2 * m_iters[i] + 4) begin
                m_k[i]      = 0;
                m_result[i] = final_ans;
                m_op[i]     = op_type;
                m_valid[i]  = 1'b1;
            end else begin
                m_k[i]++;
            end
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            check_val(i == 0 ? "ctl_iters3" : "ctl_iters1",
                      64'({en_a[i], en_b[i], en_rem[i], sel3[i], sel4[i], busy[i], done[i]}),
                      64'(exp_ctl(m_k[i], m_iters[i])));
            check_val(i == 0 ? "res_iters3" : "res_iters1",
                      64'({result[i], result_op[i], result_valid[i]}),
                      64'({m_result[i], m_op[i], m_valid[i]}));
        end
    endtask

    // One clock: check at negedge, drive new inputs, then advance the model at posedge.
    task automatic step(input logic rst, input logic st, input logic [31:0] fa,
                        input logic [1:0] op);
        @(negedge clk);
        check_outputs();
        reset     = rst;
        start     = st;
        final_ans = fa;
        op_type   = op;
        @(posedge clk);
        model_edge();
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        m_iters[0] = 3;
        m_iters[1] = 1;
        reset      = 1'b1;
        start      = 1'b0;
        final_ans  = '0;
        op_type    = '0;
        repeat (2) begin
            @(posedge clk);
            model_edge();
        end

        // Single pulse start, then idle through completion; answers include known quotients.
        step(1'b0, 1'b1, 32'h4040_0000, 2'd1);
        for (int c = 0; c < 12; c++) step(1'b0, 1'b0, 32'h4040_0000, 2'd1);
        step(1'b0, 1'b1, 32'h3EAA_AAAB, 2'd2);
        // Start pulses while busy must be ignored.
        for (int c = 0; c < 14; c++)
            step(1'b0, (c == 2 || c == 8), 32'h3EAA_AAAB, 2'd2);

        // Reset during an ITER_D cycle of the ITERS=3 instance, then a clean run.
        step(1'b0, 1'b1, $urandom, 2'($urandom));
        for (int c = 0; c < 30; c++)
            step((m_k[0] == 4 && c < 10), (c == 12), $urandom, 2'($urandom));

        // Start held high: back-to-back operations.
        for (int c = 0; c < 40; c++) step(1'b0, 1'b1, $urandom, 2'($urandom));

        // Random mix with occasional reset.
        for (int c = 0; c < 600; c++)
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0), $urandom,
                 2'($urandom));

        @(negedge clk);
        check_outputs();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
